// File: rtl/lcv_div_seq_del.sv
// lcv_div_seq_del
// Iterative restoring integer divider for the execute path (DIV/DIVU/REM/REMU).
// Each RUN cycle produces one quotient bit by conditional subtraction.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. The producer holds its payload stable while valid is high and
// ready is low. inp_* is sampled only on the accept edge. outp_* stays stable
// from the entry to DONE until the edge where outp_ready is seen high.
//
// Ports
//   clk            clock, all flops on posedge
//   rst            asynchronous active-low reset
//   inp_valid      request valid
//   inp_ready      high only in IDLE
//   inp_dividend   dividend   [WIDTH]
//   inp_divisor    divisor    [WIDTH]
//   inp_signed     1 = two's-complement divide, 0 = unsigned
//   outp_valid     result valid, high only in DONE
//   outp_ready     consumer accepts result
//   outp_quot      quotient   [WIDTH]
//   outp_rem       remainder  [WIDTH]
//   outp_div_zero  divisor was zero
//   busy           state != IDLE
module lcv_div_seq_del #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp_valid,
  output logic             inp_ready,
  input  logic [WIDTH-1:0] inp_dividend,
  input  logic [WIDTH-1:0] inp_divisor,
  input  logic             inp_signed,
  output logic             outp_valid,
  input  logic             outp_ready,
  output logic [WIDTH-1:0] outp_quot,
  output logic [WIDTH-1:0] outp_rem,
  output logic             outp_div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_RUN   = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  // dvd_q holds the raw dividend until PREP, then its magnitude, and during
  // RUN the quotient bits shift in from the bottom as dividend bits leave.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic             sgn_q;
  logic             neg_quot_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] quot_o;
  logic [WIDTH-1:0] rem_o;
  logic             dz_o;

  // PREP-stage operand decode
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             min_case;

  // RUN-stage trial subtraction
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             no_borrow;

  always_comb begin
    a_neg    = sgn_q & dvd_q[WIDTH-1];
    b_neg    = sgn_q & dsr_q[WIDTH-1];
    // Negating MIN yields MIN again, which read unsigned is 2^(WIDTH-1).
    a_mag    = a_neg ? (~dvd_q + 1'b1) : dvd_q;
    b_mag    = b_neg ? (~dsr_q + 1'b1) : dsr_q;
    min_case = sgn_q && (dvd_q == {1'b1, {(WIDTH-1){1'b0}}}) && (dsr_q == '1);
  end

  always_comb begin
    // The bit shifted out of rem is kept as bit WIDTH so divisors with the
    // MSB set still compare correctly; the kept result always fits WIDTH bits.
    rem_sh    = {rem_q, dvd_q[WIDTH-1]};
    diff      = rem_sh - {1'b0, dsr_q};
    no_borrow = (rem_sh >= {1'b0, dsr_q});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      sgn_q      <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_o     <= '0;
      rem_o      <= '0;
      dz_o       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (inp_valid) begin
            dvd_q <= inp_dividend;
            dsr_q <= inp_divisor;
            sgn_q <= inp_signed;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          neg_quot_q <= a_neg ^ b_neg;
          neg_rem_q  <= a_neg;
          if (dsr_q == '0) begin
            quot_o <= '1;
            rem_o  <= dvd_q;
            dz_o   <= 1'b1;
            state  <= S_DONE;
          end else if (min_case) begin
            quot_o <= {1'b1, {(WIDTH-1){1'b0}}};
            rem_o  <= '0;
            dz_o   <= 1'b0;
            state  <= S_DONE;
          end else begin
            dvd_q <= a_mag;
            dsr_q <= b_mag;
            rem_q <= '0;
            cnt_q <= CW'(WIDTH-1);
            state <= S_RUN;
          end
        end
        S_RUN: begin
          rem_q <= no_borrow ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          dvd_q <= {dvd_q[WIDTH-2:0], no_borrow};
          if (cnt_q == '0) begin
            state <= S_FIXUP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FIXUP: begin
          quot_o <= neg_quot_q ? (~dvd_q + 1'b1) : dvd_q;
          rem_o  <= neg_rem_q ? (~rem_q + 1'b1) : rem_q;
          dz_o   <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE: begin
          if (outp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign inp_ready     = (state == S_IDLE);
  assign outp_valid    = (state == S_DONE);
  assign busy          = (state != S_IDLE);
  assign outp_quot     = quot_o;
  assign outp_rem      = rem_o;
  assign outp_div_zero = dz_o;

endmodule

// File: tb/tb_lcv_div_seq_del.sv
// Directed bench for lcv_div_seq_del (WIDTH=32).
// Latency is counted with the accept cycle as cycle 1: a special-case result
// is visible in cycle 2, a normal result in cycle 35.
module tb_lcv_div_seq_del;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         inp_valid;
  logic         inp_ready;
  logic [W-1:0] inp_dividend;
  logic [W-1:0] inp_divisor;
  logic         inp_signed;
  logic         outp_valid;
  logic         outp_ready;
  logic [W-1:0] outp_quot;
  logic [W-1:0] outp_rem;
  logic         outp_div_zero;
  logic         busy;

  int checks = 0;
  int errors = 0;
  // Expected results, {div_zero, quot, rem}, in request order.
  logic [2*W:0] exp_q[$];

  lcv_div_seq_del #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .inp_valid     (inp_valid),
    .inp_ready     (inp_ready),
    .inp_dividend  (inp_dividend),
    .inp_divisor   (inp_divisor),
    .inp_signed    (inp_signed),
    .outp_valid    (outp_valid),
    .outp_ready    (outp_ready),
    .outp_quot     (outp_quot),
    .outp_rem      (outp_rem),
    .outp_div_zero (outp_div_zero),
    .busy          (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Presents a request, waits (bounded) for the accept edge, then scrambles
  // the inputs so any late sampling would corrupt the result.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    int n;
    n = 0;
    inp_dividend = a;
    inp_divisor  = b;
    inp_signed   = s;
    inp_valid    = 1'b1;
    while (!inp_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_ready", {63'd0, inp_ready}, 64'd1);
    @(posedge clk); #1;
    inp_valid    = 1'b0;
    inp_dividend = $urandom;
    inp_divisor  = $urandom;
    inp_signed   = 1'($urandom_range(0, 1));
    exp_q.push_back({edz, eq, er});
  endtask

  // Called right after send(); waits for outp_valid and checks latency and data.
  task automatic wait_result(input string tag, input int exp_lat);
    int lat;
    logic [2*W:0] e;
    lat = 1;
    while (!outp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk({tag, "_quot"}, 64'(outp_quot), 64'(e[2*W-1:W]));
    chk({tag, "_rem"},  64'(outp_rem),  64'(e[W-1:0]));
    chk({tag, "_dz"},   64'(outp_div_zero), 64'(e[2*W]));
  endtask

  task automatic retire(input string tag);
    outp_ready = 1'b1;
    @(posedge clk); #1;
    outp_ready = 1'b0;
    chk({tag, "_retire_valid"}, {63'd0, outp_valid}, 64'd0);
    chk({tag, "_retire_ready"}, {63'd0, inp_ready}, 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int vhits;
    rst          = 1'b0;
    inp_valid    = 1'b0;
    inp_dividend = '0;
    inp_divisor  = '0;
    inp_signed   = 1'b0;
    outp_ready   = 1'b0;
    #22;
    chk("rst_inp_ready", {63'd0, inp_ready}, 64'd1);
    chk("rst_outp_valid", {63'd0, outp_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_quot", 64'(outp_quot), 64'd0);
    chk("rst_rem", 64'(outp_rem), 64'd0);
    chk("rst_dz", {63'd0, outp_div_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Unsigned 100/7
    send(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    chk("u100_busy", {63'd0, busy}, 64'd1);
    wait_result("u100_7", 35);
    chk("u100_inp_ready_done", {63'd0, inp_ready}, 64'd0);
    retire("u100_7");

    // Signed -7/2 and 7/-2
    send(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    wait_result("s_m7_2", 35);
    retire("s_m7_2");
    send(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
    wait_result("s_7_m2", 35);
    retire("s_7_m2");

    // Divide by zero, signed and unsigned
    send(32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234, 1'b1);
    wait_result("dz_s", 2);
    retire("dz_s");
    send(32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
    wait_result("dz_u", 2);
    retire("dz_u");

    // MIN / -1, signed (special) and unsigned (normal)
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
    wait_result("min_s", 2);
    retire("min_s");
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0);
    wait_result("min_u", 35);
    retire("min_u");

    // Signed MIN / 3: magnitude path through 2^31
    send(32'h8000_0000, 32'd3, 1'b1, 32'hD555_5556, 32'hFFFF_FFFE, 1'b0);
    wait_result("min_3", 35);
    retire("min_3");

    // Backpressure: 10 cycles held in DONE, then back-to-back second request
    send(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0);
    wait_result("bp1", 35);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    chk("bp_hold_valid", {63'd0, outp_valid}, 64'd1);
    chk("bp_hold_quot", 64'(outp_quot), 64'd100);
    chk("bp_hold_rem", 64'(outp_rem), 64'd0);
    chk("bp_hold_inp_ready", {63'd0, inp_ready}, 64'd0);
    inp_dividend = 32'hFFFF_FF9C;   // -100
    inp_divisor  = 32'd7;
    inp_signed   = 1'b1;
    inp_valid    = 1'b1;
    retire("bp1");
    send(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    wait_result("bp2", 35);
    outp_ready = 1'b1;   // held high: retires in the first DONE cycle
    @(posedge clk); #1;
    chk("bp2_fast_retire", {63'd0, outp_valid}, 64'd0);
    outp_ready = 1'b0;

    // Asynchronous reset in the middle of RUN
    send(32'hDEAD_BEEF, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    chk("arst_inp_ready", {63'd0, inp_ready}, 64'd1);
    chk("arst_outp_valid", {63'd0, outp_valid}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    vhits = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (outp_valid) vhits++;
    end
    chk("arst_no_stale_valid", 64'(vhits), 64'd0);
    send(32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 1'b0);
    wait_result("post_rst", 35);
    retire("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
